pipeline_hazard_scheduler: RTL

- Scoreboard-based stall/flush scheduler for the 5-stage MIPS pipeline. It replaces per-case opcode comparisons with per-register "cycles-until-ready" counters plus a busy FSM for the non-pipelined multiplier.
- Sits beside the ID stage. Consumes decoded ID-stage operand and destination info and drives PC/IF-ID hold, ID/EX bubble and IF/ID flush.
- Keeps a saturating stall-cycle counter for lab performance reporting.

---
 rtl/hazard_pkg.sv | 37 +++
 rtl/reg_ready_scoreboard.sv | 42 ++++
 rtl/pipeline_hazard_scheduler.sv | 112 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the ID-stage hazard scheduler: latency classes, mul FSM
// states, MIPS opcodes and default pipeline latencies.
package hazard_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LOAD = 2'b01,
    CLS_MUL  = 2'b10,
    CLS_ALT  = 2'b11
  } lat_class_t;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_t;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;

  localparam int DEF_LOAD_LAT = 1;
  localparam int DEF_MUL_LAT  = 4;
  localparam int DEF_BR_EXTRA = 1;
  localparam int DEF_CNT_W    = 3;

  // Cycles until a producer's result reaches an EX consumer; class 11 acts as ALU.
  function automatic int class_latency(input logic [1:0] cls, input int load_lat,
                                       input int mul_lat);
    case (lat_class_t'(cls))
      CLS_LOAD: return load_lat;
      CLS_MUL:  return mul_lat - 1;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/reg_ready_scoreboard.sv
// Per-register cycles-until-ready counters for $1..$31 with two read ports;
// $0 always reads as ready.
module reg_ready_scoreboard
  import hazard_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic [4:0]       load_addr,
  input  logic [CNT_W-1:0] load_val,
  input  logic [4:0]       addr_a,
  input  logic [4:0]       addr_b,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic [CNT_W-1:0] cnt [1:31];

  // A fresh producer load wins over the decrement of the same register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (load_en && load_addr == 5'(i))
          cnt[i] <= load_val;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt_a = '0;
    cnt_b = '0;
    if (addr_a != 5'd0) cnt_a = cnt[addr_a];
    if (addr_b != 5'd0) cnt_b = cnt[addr_b];
  end

endmodule

// File: rtl/pipeline_hazard_scheduler.sv
// Scoreboard-driven stall/flush control beside the ID stage, with a busy FSM
// for the non-pipelined multiplier and a saturating stall-cycle counter.
module pipeline_hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int MUL_LAT  = DEF_MUL_LAT,
  parameter int BR_EXTRA = DEF_BR_EXTRA,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ID_valid,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_uses_rs,
  input  logic        ID_uses_rt,
  input  logic        ID_is_branch,
  input  logic        ID_writes,
  input  logic [4:0]  ID_rdest,
  input  logic [1:0]  ID_class,
  input  logic        Branch_taken,
  output logic        Stall_PC,
  output logic        Stall_ID,
  output logic        Bubble_ID_EX,
  output logic        Flush_IF_ID,
  output logic        Issue,
  output logic        Mul_busy,
  output logic [31:0] Stall_count
);

  logic [CNT_W-1:0] cnt_rs, cnt_rt, thr, load_val, mul_cnt, mul_cnt_next;
  logic             raw_haz, struct_haz, stall, issue_int, load_en;
  mul_state_t       state, state_next;
  lat_class_t       cls;

  assign cls = lat_class_t'(ID_class);

  // Branches compare in ID, so they need one extra cycle of readiness margin.
  assign thr        = ID_is_branch ? '0 : CNT_W'(BR_EXTRA);
  assign raw_haz    = ID_valid &&
                      ((ID_uses_rs && ID_rs != 5'd0 && cnt_rs > thr) ||
                       (ID_uses_rt && ID_rt != 5'd0 && cnt_rt > thr));
  assign struct_haz = ID_valid && cls == CLS_MUL && state == MUL_BUSY;
  assign stall      = raw_haz || struct_haz;
  assign issue_int  = ID_valid && !stall;

  assign Stall_PC     = Reset && stall;
  assign Stall_ID     = Reset && stall;
  assign Bubble_ID_EX = Reset && stall;
  assign Issue        = Reset && issue_int;
  assign Flush_IF_ID  = Reset && issue_int && ID_is_branch && Branch_taken;
  assign Mul_busy     = state == MUL_BUSY;

  assign load_en  = issue_int && ID_writes && ID_rdest != 5'd0;
  assign load_val = CNT_W'(class_latency(ID_class, LOAD_LAT, MUL_LAT) + BR_EXTRA);

  reg_ready_scoreboard #(.CNT_W(CNT_W)) u_scoreboard (
    .clock    (Clock),
    .reset_n  (Reset),
    .load_en  (load_en),
    .load_addr(ID_rdest),
    .load_val (load_val),
    .addr_a   (ID_rs),
    .addr_b   (ID_rt),
    .cnt_a    (cnt_rs),
    .cnt_b    (cnt_rt)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= MUL_IDLE;
      mul_cnt <= '0;
    end else begin
      state   <= state_next;
      mul_cnt <= mul_cnt_next;
    end
  end

  // Busy covers exactly MUL_LAT-1 cycles after the issuing cycle.
  always_comb begin
    state_next   = state;
    mul_cnt_next = mul_cnt;
    case (state)
      MUL_IDLE: begin
        if (issue_int && cls == CLS_MUL && MUL_LAT > 1) begin
          state_next   = MUL_BUSY;
          mul_cnt_next = CNT_W'(MUL_LAT - 1);
        end
      end
      MUL_BUSY: begin
        mul_cnt_next = mul_cnt - CNT_W'(1);
        if (mul_cnt <= CNT_W'(1)) begin
          state_next   = MUL_IDLE;
          mul_cnt_next = '0;
        end
      end
      default: begin
        state_next   = MUL_IDLE;
        mul_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset)
      Stall_count <= '0;
    else if (stall && Stall_count != 32'hFFFF_FFFF)
      Stall_count <= Stall_count + 32'd1;
  end

endmodule
